// File: rtl/icache_pkg.sv
// Shared types, default geometry and FSM encoding for the instruction cache.
package icache_pkg;

   localparam int ICACHE_IDX_WIDTH = 6;

   typedef logic [31:0] addr_t;
   typedef logic [31:0] ins_t;

   typedef enum logic {
      ICACHE_IDLE = 1'b0,
      ICACHE_MISS = 1'b1
   } state_t;

   function automatic int tag_width(input int idx_width);
      return 30 - idx_width;
   endfunction

endpackage

// File: rtl/icache_line_array.sv
// Direct-mapped line storage: reset-cleared valid bits, tag and data registers.
// Combinational read on the index, single synchronous write port.
module icache_line_array
   import icache_pkg::*;
#(
   parameter int IDX_WIDTH = ICACHE_IDX_WIDTH,
   parameter int TAG_W     = tag_width(ICACHE_IDX_WIDTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [IDX_WIDTH-1:0] rd_idx,
   output logic                 rd_valid,
   output logic [TAG_W-1:0]     rd_tag,
   output logic [31:0]          rd_data,
   input  logic                 wr_en,
   input  logic [IDX_WIDTH-1:0] wr_idx,
   input  logic [TAG_W-1:0]     wr_tag,
   input  logic [31:0]          wr_data
);

   localparam int LINES = 1 << IDX_WIDTH;

   logic [LINES-1:0] valid;
   logic [TAG_W-1:0] tags [LINES];
   ins_t             data [LINES];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         valid <= '0;
      else if (wr_en)
         valid[wr_idx] <= 1'b1;
   end

   // Tag and data need no reset: a line is only consulted once its valid bit is set.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tags[wr_idx] <= wr_tag;
         data[wr_idx] <= wr_data;
      end
   end

   assign rd_valid = valid[rd_idx];
   assign rd_tag   = tags[rd_idx];
   assign rd_data  = data[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped icache: hit answers one cycle after the request, miss refills via memCtrl.
// Accepts a new request only while if_ready; rdy=0 freezes everything; clear drops in-flight responses.
module icache
   import icache_pkg::*;
#(
   parameter int IDX_WIDTH = ICACHE_IDX_WIDTH
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        clear,
   input  logic        if_req,
   input  logic [31:0] if_pc,
   output logic        if_ready,
   output logic        inst_valid,
   output logic [31:0] inst_out,
   output logic        mem_flag,
   output logic [31:0] mem_addr,
   input  logic        mem_done,
   input  logic [31:0] mem_inst
);

   localparam int TAG_W = tag_width(IDX_WIDTH);

   state_t               state;
   logic                 drop;
   logic                 line_valid;
   logic [TAG_W-1:0]     line_tag;
   ins_t                 line_data;
   logic                 hit;
   logic                 fill;
   logic [IDX_WIDTH-1:0] req_idx;
   logic [TAG_W-1:0]     req_tag;
   logic                 unused_pc_bits;

   assign req_idx        = if_pc[IDX_WIDTH+1:2];
   assign req_tag        = if_pc[31:IDX_WIDTH+2];
   assign unused_pc_bits = &{1'b0, if_pc[1:0]};
   assign hit            = line_valid && (line_tag == req_tag);
   // The refill address is held in mem_addr for the whole miss, so it doubles as the write address.
   assign fill           = rdy && (state == ICACHE_MISS) && mem_done;

   icache_line_array #(
      .IDX_WIDTH (IDX_WIDTH),
      .TAG_W     (TAG_W)
   ) u_lines (
      .clk      (clk),
      .rst      (rst),
      .rd_idx   (req_idx),
      .rd_valid (line_valid),
      .rd_tag   (line_tag),
      .rd_data  (line_data),
      .wr_en    (fill),
      .wr_idx   (mem_addr[IDX_WIDTH+1:2]),
      .wr_tag   (mem_addr[31:IDX_WIDTH+2]),
      .wr_data  (mem_inst)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ICACHE_IDLE;
         drop       <= 1'b0;
         if_ready   <= 1'b1;
         inst_valid <= 1'b0;
         inst_out   <= '0;
         mem_flag   <= 1'b0;
         mem_addr   <= '0;
      end else if (rdy) begin
         inst_valid <= 1'b0;
         case (state)
            ICACHE_IDLE: begin
               if (if_req && !clear) begin
                  if (hit) begin
                     inst_out   <= line_data;
                     inst_valid <= 1'b1;
                  end else begin
                     mem_addr <= {if_pc[31:2], 2'b00};
                     mem_flag <= 1'b1;
                     drop     <= 1'b0;
                     if_ready <= 1'b0;
                     state    <= ICACHE_MISS;
                  end
               end
            end
            ICACHE_MISS: begin
               if (clear)
                  drop <= 1'b1;
               // The fill always lands; only the response to the fetcher is suppressed after a flush.
               if (mem_done) begin
                  mem_flag <= 1'b0;
                  if_ready <= 1'b1;
                  state    <= ICACHE_IDLE;
                  if (!drop && !clear) begin
                     inst_valid <= 1'b1;
                     inst_out   <= mem_inst;
                  end
               end
            end
            default: state <= ICACHE_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_icache.sv
// Directed table-driven bench for icache plus hand sequences for flush, stall and reset.
module tb_icache;

   logic        clk;
   logic        rst;
   logic        rdy;
   logic        clear;
   logic        if_req;
   logic [31:0] if_pc;
   logic        if_ready;
   logic        inst_valid;
   logic [31:0] inst_out;
   logic        mem_flag;
   logic [31:0] mem_addr;
   logic        mem_done;
   logic [31:0] mem_inst;

   int checks = 0;
   int errors = 0;

   icache #(.IDX_WIDTH(6)) dut (
      .clk        (clk),
      .rst        (rst),
      .rdy        (rdy),
      .clear      (clear),
      .if_req     (if_req),
      .if_pc      (if_pc),
      .if_ready   (if_ready),
      .inst_valid (inst_valid),
      .inst_out   (inst_out),
      .mem_flag   (mem_flag),
      .mem_addr   (mem_addr),
      .mem_done   (mem_done),
      .mem_inst   (mem_inst)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;   // refill data on a miss, expected data on a hit
      bit          miss;
      int          lat;    // idle cycles before mem_done
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Issue one request at a negedge and follow it through hit or miss, checking every output.
   task automatic request(input vec_t v);
      chk("req_if_ready", {31'd0, if_ready}, 32'd1);
      if_req = 1'b1;
      if_pc  = v.pc;
      @(negedge clk);
      if_req = 1'b0;
      if (!v.miss) begin
         chk("hit_valid", {31'd0, inst_valid}, 32'd1);
         chk("hit_data", inst_out, v.inst);
         chk("hit_no_memflag", {31'd0, mem_flag}, 32'd0);
      end else begin
         chk("miss_flag", {31'd0, mem_flag}, 32'd1);
         chk("miss_addr", mem_addr, {v.pc[31:2], 2'b00});
         chk("miss_not_ready", {31'd0, if_ready}, 32'd0);
         chk("miss_no_valid", {31'd0, inst_valid}, 32'd0);
         for (int i = 0; i < v.lat; i++) begin
            @(negedge clk);
            chk("miss_flag_held", {31'd0, mem_flag}, 32'd1);
         end
         mem_done = 1'b1;
         mem_inst = v.inst;
         @(negedge clk);
         mem_done = 1'b0;
         mem_inst = 32'hx;
         chk("fill_valid", {31'd0, inst_valid}, 32'd1);
         chk("fill_data", inst_out, v.inst);
         chk("fill_flag_low", {31'd0, mem_flag}, 32'd0);
         chk("fill_ready", {31'd0, if_ready}, 32'd1);
      end
      @(negedge clk);
      chk("pulse_end", {31'd0, inst_valid}, 32'd0);
   endtask

   function automatic vec_t mk(input logic [31:0] pc, input logic [31:0] inst, input bit miss, input int lat);
      vec_t v;
      v.pc = pc; v.inst = inst; v.miss = miss; v.lat = lat;
      return v;
   endfunction

   initial begin
      rst = 1'b0; rdy = 1'b1; clear = 1'b0; if_req = 1'b0; if_pc = '0;
      mem_done = 1'b0; mem_inst = '0;

      vecs[0] = mk(32'h0000_0010, 32'h0000_0093, 1'b1, 2);  // cold miss
      vecs[1] = mk(32'h0000_0010, 32'h0000_0093, 1'b0, 0);  // hit after fill
      vecs[2] = mk(32'h0000_0013, 32'h0000_0093, 1'b0, 0);  // offset bits ignored
      vecs[3] = mk(32'h0000_0110, 32'h00A0_0113, 1'b1, 0);  // same index, new tag
      vecs[4] = mk(32'h0000_0110, 32'h00A0_0113, 1'b0, 0);
      vecs[5] = mk(32'h0000_0010, 32'h0000_0093, 1'b1, 1);  // evicted, refetch
      vecs[6] = mk(32'hFFFF_FFFC, 32'hDEAD_BEEF, 1'b1, 3);  // top index, all-ones tag
      vecs[7] = mk(32'hFFFF_FFFC, 32'hDEAD_BEEF, 1'b0, 0);
      vecs[8] = mk(32'h0000_0014, 32'h1234_5678, 1'b1, 0);
      vecs[9] = mk(32'h0000_0010, 32'h0000_0093, 1'b0, 0);

      #12;
      chk("rst_if_ready", {31'd0, if_ready}, 32'd1);
      chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
      chk("rst_inst_out", inst_out, 32'd0);
      chk("rst_mem_flag", {31'd0, mem_flag}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 10; i++)
         request(vecs[i]);

      // Flush two cycles before the refill: line written, no response.
      if_req = 1'b1; if_pc = 32'h0000_0020;
      @(negedge clk);
      if_req = 1'b0;
      chk("flush_miss_flag", {31'd0, mem_flag}, 32'd1);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      @(negedge clk);
      chk("flush_flag_kept", {31'd0, mem_flag}, 32'd1);
      mem_done = 1'b1; mem_inst = 32'h0000_0555;
      @(negedge clk);
      mem_done = 1'b0;
      chk("flush_no_valid", {31'd0, inst_valid}, 32'd0);
      chk("flush_ready", {31'd0, if_ready}, 32'd1);
      chk("flush_flag_low", {31'd0, mem_flag}, 32'd0);
      request(mk(32'h0000_0020, 32'h0000_0555, 1'b0, 0));

      // Clear coincident with mem_done.
      if_req = 1'b1; if_pc = 32'h0000_0024;
      @(negedge clk);
      if_req = 1'b0;
      clear = 1'b1; mem_done = 1'b1; mem_inst = 32'h0000_0777;
      @(negedge clk);
      clear = 1'b0; mem_done = 1'b0;
      chk("coinc_no_valid", {31'd0, inst_valid}, 32'd0);
      chk("coinc_ready", {31'd0, if_ready}, 32'd1);
      request(mk(32'h0000_0024, 32'h0000_0777, 1'b0, 0));

      // Clear in IDLE swallows the same-cycle request, hit or miss.
      if_req = 1'b1; if_pc = 32'h0000_0010; clear = 1'b1;
      @(negedge clk);
      chk("idle_clr_hit_none", {31'd0, inst_valid}, 32'd0);
      if_pc = 32'h0000_0080;
      @(negedge clk);
      if_req = 1'b0; clear = 1'b0;
      chk("idle_clr_miss_flag", {31'd0, mem_flag}, 32'd0);
      chk("idle_clr_ready", {31'd0, if_ready}, 32'd1);

      // rdy low during the hit response window: outputs held, new request ignored.
      if_req = 1'b1; if_pc = 32'h0000_0010;
      @(negedge clk);
      rdy = 1'b0; if_pc = 32'h0000_0200;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_valid", {31'd0, inst_valid}, 32'd1);
         chk("stall_data", inst_out, 32'h0000_0093);
         chk("stall_flag", {31'd0, mem_flag}, 32'd0);
         chk("stall_ready", {31'd0, if_ready}, 32'd1);
      end
      rdy = 1'b1; if_req = 1'b0;
      @(negedge clk);
      chk("stall_resume", {31'd0, inst_valid}, 32'd0);

      // mem_done during rdy low is not sampled.
      if_req = 1'b1; if_pc = 32'h0000_0030;
      @(negedge clk);
      if_req = 1'b0; rdy = 1'b0; mem_done = 1'b1; mem_inst = 32'h0000_0333;
      @(negedge clk);
      @(negedge clk);
      chk("frz_flag", {31'd0, mem_flag}, 32'd1);
      chk("frz_no_valid", {31'd0, inst_valid}, 32'd0);
      rdy = 1'b1;
      @(negedge clk);
      mem_done = 1'b0;
      chk("frz_fill_valid", {31'd0, inst_valid}, 32'd1);
      chk("frz_fill_data", inst_out, 32'h0000_0333);
      @(negedge clk);

      // Reset mid-miss.
      if_req = 1'b1; if_pc = 32'h0000_0040;
      @(negedge clk);
      if_req = 1'b0;
      chk("rmiss_flag", {31'd0, mem_flag}, 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("rmiss_flag_low", {31'd0, mem_flag}, 32'd0);
      chk("rmiss_ready", {31'd0, if_ready}, 32'd1);
      chk("rmiss_addr", mem_addr, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      request(mk(32'h0000_0040, 32'h0000_0444, 1'b1, 1));
      request(mk(32'h0000_0010, 32'h0000_0093, 1'b1, 0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/icache.md
# icache

Direct-mapped instruction cache between the instruction fetcher and `memCtrl`. It accepts one PC request at a time from the fetcher and returns the 32-bit instruction one cycle later on a hit. On a miss it issues a fetch to `memCtrl` on the `flag_from_if` / `mem_req_from_if` pair, fills the line, then responds. It also absorbs pipeline flushes, so a stale refill never reaches the fetcher.

## Interface
- `IDX_WIDTH`, 6: index bits; line count = 2^IDX_WIDTH, one 32-bit word per line.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `rdy` in 1: global enable; low freezes all state and outputs.
- `clear` in 1: flush from ROB mispredict; abandons the current request.
- `if_req` in 1: fetcher request valid.
- `if_pc` in 32: request address; bits [1:0] ignored.
- `if_ready` out 1: cache can accept a request (state IDLE).
- `inst_valid` out 1: one-cycle response pulse.
- `inst_out` out 32: instruction; valid only while `inst_valid`=1.
- `mem_flag` out 1: to `memCtrl.flag_from_if`; held high until served.
- `mem_addr` out 32: to `memCtrl.mem_req_from_if`; word-aligned.
- `mem_done` in 1: from `memCtrl.flag_to_if`.
- `mem_inst` in 32: from `memCtrl.inst_to_if`; sampled when `mem_done`=1.

## Operation
- Address split: offset = pc[1:0]; index = pc[IDX_WIDTH+1:2]; tag = pc[31:IDX_WIDTH+2].
- Storage per line: valid bit, tag, 32-bit data. Only the valid bits are reset, all to 0.
- States:
  - IDLE: `if_ready`=1.
  - MISS: waiting for `mem_done`.
  - Each state records a `drop` flag.
- IDLE, edge with `if_req`=1 and `clear`=0, hit (valid and tag match):
  - `inst_out` <= line data; `inst_valid` <= 1.
  - Stay in IDLE.
- IDLE, edge with `if_req`=1 and `clear`=0, miss:
  - Latch `{pc[31:2],2'b00}` into `mem_addr`; `mem_flag` <= 1; `drop` <= 0.
  - Go to MISS.
- MISS, edge with `mem_done`=1:
  - Write the line: valid=1, tag, data = `mem_inst`.
  - `mem_flag` <= 0.
  - If `drop`=0: `inst_valid` <= 1 and `inst_out` <= `mem_inst`.
  - Go to IDLE.
- `clear`:
  - In IDLE: the request in the same cycle is ignored, and `inst_valid` <= 0 at that edge.
  - In MISS: `drop` <= 1. The `memCtrl` request is not withdrawn; the refill still completes and the line is still written, because the data is correct for that address. No response is produced.
  - `clear` coincident with `mem_done`: line written, response suppressed.
- `inst_valid` is 0 on every edge not listed above.
- `rdy`=0: no state, storage or output changes. `mem_done` arriving while `rdy`=0 is not sampled; `memCtrl` must hold it.
- Reset assertion at any time: immediate return to IDLE, all valid bits 0, any pending miss abandoned.
  - Reset output values: `if_ready`=1, `inst_valid`=0, `inst_out`=0, `mem_flag`=0, `mem_addr`=0.

## Timing
- Hit latency: request sampled at edge N, `inst_valid`=1 during cycle N→N+1.
- Miss: `mem_flag` rises after edge N and stays high through the edge where `mem_done` is sampled (edge M). `inst_valid`=1 during cycle M→M+1.
- `if_ready` falls after edge N and rises after edge M.
- The earliest next request is sampled at edge M+1. Back-to-back hits sustain one instruction per cycle.
- `if_ready` is a registered state decode, with no combinational path from `if_req`.
- The read of the line array is combinational on `if_pc`; all outputs are registered.

## Structure
- `definition.v` holds:
  - `ADDR_TYPE` and `INS_TYPE` (31:0);
  - the `ICACHE_IDX_WIDTH` default;
  - the `ICACHE_IDLE` / `ICACHE_MISS` state encodings.
- Sub-module `icache_line_array`:
  - async-reset valid bit vector;
  - tag and data register arrays;
  - one combinational read port and one synchronous write port.
- The top level contains the FSM, the `drop` flag and the output registers.

## Test plan
- Cold miss: reset, request pc=0x0000_0010.
  - `mem_flag`=1 with `mem_addr`=0x10 until `mem_done`.
  - `mem_done` with `mem_inst`=0x0000_0093 → `inst_valid`=1 and `inst_out`=0x93 next cycle.
- Hit after fill: repeat pc=0x10.
  - `inst_valid`=1 one cycle later with 0x93; `mem_flag` stays 0.
- Conflict: pc=0x10 then pc=0x110 (IDX_WIDTH=6, same index, different tag).
  - Second request misses and refetches.
  - Third request pc=0x10 misses again.
- Flush mid-miss: miss on pc=0x20, `clear` pulsed 2 cycles before `mem_done`.
  - No `inst_valid`; a later request for pc=0x20 hits.
- `rdy`=0 for 3 cycles during a hit response window.
  - `inst_valid` and `inst_out` held, no state change; resumes on `rdy`=1.
- Reset mid-miss: assert `rst`=0 while in MISS.
  - `mem_flag`=0 immediately; `if_ready`=1; a later request for the same pc misses.
